bram_port_arbiter: RTL and testbench

// - Shares one block-RAM port (ena/wea/addr/din/dout, 1-cycle or more read latency) between two requesters.
// - Example pairing: the switch/pushbutton front end and a scan/display engine.
// - Round-robin arbitration: one access per cycle, no starvation.
// - Read data is routed back to the requester that issued the read, with a one-cycle rvalid pulse.
// - Sits between the requesters and the RAM wrapper (for example, blk_mem_gen port A or B).
//

---
 rtl/bram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: lets two requesters share one block-RAM port.
// Round-robin grant, one access per cycle, and read data steered back to
// the requester that issued the read through a short tag pipe that matches
// the RAM read latency.
module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // requester 1
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // Id of the requester granted most recently; 1 after reset so that
  // requester 0 wins the first contention.
  logic last;

  // Read-tag pipe: stage RD_LAT-1 lines up with valid mem_dout.
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_id;
  logic [RD_LAT-1:0] valid_next;
  logic [RD_LAT-1:0] id_next;

  logic grant0;
  logic grant1;
  logic push_read;

  // Round-robin pick: a lone requester always wins, contention goes to
  // whoever was not granted last time. Nothing is granted during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign gnt0 = grant0;
  assign gnt1 = grant1;

  // Steer the winner's command onto the RAM port; with no grant the
  // address/data buses idle on requester 0's values.
  always_comb begin
    mem_en = grant0 | grant1;
    if (grant1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end else begin
      mem_we   = grant0 & we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end
  end

  // Only reads enter the tag pipe as valid; writes occupy a slot as a bubble.
  assign push_read = mem_en & ~mem_we;

  // The tag pipe shifts by one stage per clock; a one-deep pipe has no
  // older stages to carry forward.
  if (RD_LAT == 1) begin : g_pipe_one
    assign valid_next = push_read;
    assign id_next    = grant1;
  end else begin : g_pipe_many
    assign valid_next = {pipe_valid[RD_LAT-2:0], push_read};
    assign id_next    = {pipe_id[RD_LAT-2:0], grant1};
  end

  // Remember who won so the next contention goes the other way.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant0) begin
      last <= 1'b0;
    end else if (grant1) begin
      last <= 1'b1;
    end
  end

  // Advance the read tags; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid <= valid_next;
      pipe_id    <= id_next;
    end
  end

  assign rvalid0 = pipe_valid[RD_LAT-1] & ~pipe_id[RD_LAT-1] & ~reset;
  assign rvalid1 = pipe_valid[RD_LAT-1] &  pipe_id[RD_LAT-1] & ~reset;

  assign rdata0 = mem_dout;
  assign rdata1 = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed bench for bram_port_arbiter with a
// behavioural RAM, a queue-based reference model checked every cycle,
// and literal expectations for each directed scenario.
module tb_bram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  logic              clk;
  logic              reset;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .we0(we0),
    .addr0(addr0),
    .wdata0(wdata0),
    .gnt0(gnt0),
    .rvalid0(rvalid0),
    .rdata0(rdata0),
    .req1(req1),
    .we1(we1),
    .addr1(addr1),
    .wdata1(wdata1),
    .gnt1(gnt1),
    .rvalid1(rvalid1),
    .rdata1(rdata1),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: unwritten words read as 16'hA000 + address.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  bit   [(1<<ADDR_W)-1:0] ram_set;
  logic [DATA_W-1:0] dout_pipe [RD_LAT];

  // RAM port: write on enable+we, read data appears RD_LAT clocks later.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]     <= mem_din;
      ram_set[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      dout_pipe[0] <= ram_set[mem_addr] ? ram[mem_addr] : (16'hA000 + 16'(mem_addr));
    end
    for (int i = 1; i < RD_LAT; i++) begin
      dout_pipe[i] <= dout_pipe[i-1];
    end
  end

  assign mem_dout = dout_pipe[RD_LAT-1];

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state: who won last, a shadow of RAM contents and
  // the list of reads owed back to requesters with their due cycle.
  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } ret_t;

  ret_t        ret_q[$];
  int          prev_winner = 1;
  int          cyc = 0;
  logic [15:0] shadow [0:(1<<ADDR_W)-1];
  bit          shadow_set [0:(1<<ADDR_W)-1];

  task automatic model_step();
    int          winner;
    bit          exp_rv0;
    bit          exp_rv1;
    bit          exp_we;
    logic [15:0] exp_rd;
    logic [15:0] exp_addr;
    ret_t        r;
    winner  = -1;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    exp_rd  = '0;
    if (!reset) begin
      if (req0 && req1) winner = (prev_winner == 0) ? 1 : 0;
      else if (req0)    winner = 0;
      else if (req1)    winner = 1;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        if (ret_q[0].id == 0) exp_rv0 = 1'b1;
        else                  exp_rv1 = 1'b1;
        exp_rd = ret_q[0].data;
        void'(ret_q.pop_front());
      end
    end
    exp_we   = (winner == 0) ? we0 : (winner == 1) ? we1 : 1'b0;
    exp_addr = (winner == 1) ? 16'(addr1) : 16'(addr0);
    check_bit("model_gnt0", gnt0, winner == 0);
    check_bit("model_gnt1", gnt1, winner == 1);
    check_bit("model_mem_en", mem_en, winner >= 0);
    check_bit("model_mem_we", mem_we, exp_we);
    check_word("model_mem_addr", 16'(mem_addr), exp_addr);
    if (winner >= 0 && exp_we)
      check_word("model_mem_din", mem_din, (winner == 1) ? wdata1 : wdata0);
    check_bit("model_rvalid0", rvalid0, exp_rv0);
    check_bit("model_rvalid1", rvalid1, exp_rv1);
    if (exp_rv0) check_word("model_rdata0", rdata0, exp_rd);
    if (exp_rv1) check_word("model_rdata1", rdata1, exp_rd);
    if (reset) begin
      prev_winner = 1;
      ret_q.delete();
    end else if (winner >= 0) begin
      prev_winner = winner;
      exp_addr = (winner == 1) ? 16'(addr1) : 16'(addr0);
      if (exp_we) begin
        shadow[exp_addr[ADDR_W-1:0]]     = (winner == 1) ? wdata1 : wdata0;
        shadow_set[exp_addr[ADDR_W-1:0]] = 1'b1;
      end else begin
        r.due  = cyc + RD_LAT;
        r.id   = winner;
        r.data = shadow_set[exp_addr[ADDR_W-1:0]] ? shadow[exp_addr[ADDR_W-1:0]]
                                                  : (16'hA000 + exp_addr);
        ret_q.push_back(r);
      end
    end
    cyc++;
  endtask

  // Compare the DUT against the model midway through every cycle.
  always @(negedge clk) model_step();

  task automatic apply_stimulus(input bit rst,
                                input bit r0, input bit w0, input logic [ADDR_W-1:0] a0,
                                input logic [DATA_W-1:0] d0,
                                input bit r1, input bit w1, input logic [ADDR_W-1:0] a1,
                                input logic [DATA_W-1:0] d1);
    @(posedge clk);
    #1;
    reset  = rst;
    req0   = r0;
    we0    = w0;
    addr0  = a0;
    wdata0 = d0;
    req1   = r1;
    we1    = w1;
    addr1  = a1;
    wdata1 = d1;
  endtask

  task automatic apply_idle(input bit rst);
    apply_stimulus(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset  = 1'b1;
    req0   = 1'b1;
    we0    = 1'b0;
    addr0  = '0;
    wdata0 = '0;
    req1   = 1'b1;
    we1    = 1'b0;
    addr1  = '0;
    wdata1 = '0;

    // Reset forces everything quiet even with both requests up
    @(negedge clk);
    check_bit("reset_gnt0", gnt0, 1'b0);
    check_bit("reset_gnt1", gnt1, 1'b0);
    check_bit("reset_mem_en", mem_en, 1'b0);
    check_bit("reset_mem_we", mem_we, 1'b0);
    check_bit("reset_rvalid0", rvalid0, 1'b0);
    check_bit("reset_rvalid1", rvalid1, 1'b0);
    apply_idle(1'b1);

    // Write then read of address 5
    apply_stimulus(1'b0, 1'b1, 1'b1, 10'd5, 16'hBEEF, 1'b0, 1'b0, 10'd0, 16'h0);
    @(negedge clk);
    check_bit("wr_gnt0", gnt0, 1'b1);
    check_bit("wr_mem_we", mem_we, 1'b1);
    check_word("wr_mem_addr", 16'(mem_addr), 16'd5);
    check_word("wr_mem_din", mem_din, 16'hBEEF);
    apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'd5, 16'h0);
    @(negedge clk);
    check_bit("rd_gnt1", gnt1, 1'b1);
    check_bit("rd_mem_we", mem_we, 1'b0);
    apply_idle(1'b0);
    @(negedge clk);
    check_bit("rd_rvalid1", rvalid1, 1'b1);
    check_word("rd_rdata1", rdata1, 16'hBEEF);
    check_bit("rd_rvalid0", rvalid0, 1'b0);

    // Contention: both read for six cycles, grants alternate 0,1,...
    apply_idle(1'b1);
    for (int k = 0; k < 7; k++) begin
      if (k < 6) apply_stimulus(1'b0, 1'b1, 1'b0, 10'd10, 16'h0, 1'b1, 1'b0, 10'd20, 16'h0);
      else       apply_idle(1'b0);
      @(negedge clk);
      if (k < 6) begin
        check_bit("cont_gnt0", gnt0, (k % 2) == 0);
        check_bit("cont_gnt1", gnt1, (k % 2) == 1);
      end
      if (k >= 1) begin
        check_bit("cont_rvalid0", rvalid0, ((k - 1) % 2) == 0);
        check_bit("cont_rvalid1", rvalid1, ((k - 1) % 2) == 1);
        check_word("cont_rdata", rdata0, (((k - 1) % 2) == 0) ? 16'hA00A : 16'hA014);
      end
    end

    // Requester 1 streams reads of addresses 0..3
    for (int k = 0; k < 6; k++) begin
      if (k < 4) apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'(k), 16'h0);
      else       apply_idle(1'b0);
      @(negedge clk);
      if (k < 4) check_bit("stream_gnt1", gnt1, 1'b1);
      if (k >= 1 && k <= 4) begin
        check_bit("stream_rvalid1", rvalid1, 1'b1);
        check_word("stream_rdata1", rdata1, 16'hA000 + 16'(k - 1));
      end
    end

    // Reset lands on the cycle after a granted read
    apply_stimulus(1'b0, 1'b1, 1'b0, 10'd7, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    @(negedge clk);
    check_bit("rst_mid_gnt0", gnt0, 1'b1);
    apply_idle(1'b1);
    @(negedge clk);
    check_bit("rst_mid_rvalid0_a", rvalid0, 1'b0);
    apply_idle(1'b0);
    @(negedge clk);
    check_bit("rst_mid_rvalid0_b", rvalid0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 10'd7, 16'h0, 1'b1, 1'b0, 10'd8, 16'h0);
    @(negedge clk);
    check_bit("rst_mid_first_gnt0", gnt0, 1'b1);
    check_bit("rst_mid_first_gnt1", gnt1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'd8, 16'h0);
    @(negedge clk);
    check_bit("rst_mid_next_gnt1", gnt1, 1'b1);
    check_bit("rst_mid_reissue_rvalid0", rvalid0, 1'b1);
    check_word("rst_mid_reissue_rdata0", rdata0, 16'hA007);
    apply_idle(1'b0);
    @(negedge clk);
    check_bit("rst_mid_rvalid1", rvalid1, 1'b1);
    check_word("rst_mid_rdata1", rdata1, 16'hA008);

    // Simultaneous write and read of address 9
    apply_idle(1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 10'd9, 16'h1234, 1'b1, 1'b0, 10'd9, 16'h0);
    @(negedge clk);
    check_bit("sim_gnt0", gnt0, 1'b1);
    check_bit("sim_gnt1", gnt1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'd9, 16'h0);
    @(negedge clk);
    check_bit("sim_next_gnt1", gnt1, 1'b1);
    apply_idle(1'b0);
    @(negedge clk);
    check_bit("sim_rvalid1", rvalid1, 1'b1);
    check_word("sim_rdata1", rdata1, 16'h1234);

    // Requester 1 withdraws in a cycle that requester 0 wins
    apply_stimulus(1'b0, 1'b1, 1'b0, 10'd3, 16'h0, 1'b1, 1'b0, 10'd4, 16'h0);
    @(negedge clk);
    check_bit("wd_gnt0", gnt0, 1'b1);
    check_bit("wd_gnt1", gnt1, 1'b0);
    check_word("wd_mem_addr", 16'(mem_addr), 16'd3);
    apply_idle(1'b0);
    @(negedge clk);
    check_bit("wd_after_gnt1", gnt1, 1'b0);
    check_bit("wd_after_mem_en", mem_en, 1'b0);
    check_bit("wd_rvalid0", rvalid0, 1'b1);
    check_bit("wd_rvalid1", rvalid1, 1'b0);
    check_word("wd_rdata0", rdata0, 16'hA003);
    apply_idle(1'b0);
    @(negedge clk);
    check_bit("wd_late_rvalid1", rvalid1, 1'b0);

    apply_idle(1'b0);
    apply_idle(1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
